// File: rtl/mmio_csr_bank_pkg.sv
// mmio_csr_bank_pkg: shared types and helpers for the MMIO CSR bank.
//   - PSL MMIO request/response structs (big-endian bit numbering as on PSL).
//   - Region decode enum, pipeline stage structs.
//   - 2-bit MMIO error encoding {data parity, address parity}.
//   - Half-word write mask and read-mux helper functions.
package mmio_csr_bank_pkg;

    // Width of a register index after (dw_addr - base) >> 1.
    localparam int unsigned IDX_W    = 22;
    // Width of an in-region register select (regions hold up to 16 entries).
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned MAX_REGS = 16;

    typedef logic [1:0] mmio_err_t;
    localparam mmio_err_t MMIO_ERR_NONE = 2'b00;
    localparam mmio_err_t MMIO_ERR_ADDR = 2'b01;
    localparam mmio_err_t MMIO_ERR_DATA = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        cfg;
        logic        read;
        logic        doubleword;
        logic [0:23] address;
        logic        address_parity;
        logic [0:63] data;
        logic        data_parity;
    } MMIOInterfaceInput;

    typedef struct packed {
        logic        ack;
        logic [0:63] data;
        logic        data_parity;
    } MMIOInterfaceOutput;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_CTRL,
        REGION_STICKY,
        REGION_RAW
    } csr_region_e;

    // Decoded access, held between decode and register update.
    typedef struct packed {
        logic             valid;
        logic             read;
        logic             dw;
        logic             lo_half;
        csr_region_e      region;
        logic [SEL_W-1:0] sel;
        logic             commit;
        logic [63:0]      wdata;
        mmio_err_t        err;
    } csr_dec_t;

    // Access state carried into the read-mux stage.
    typedef struct packed {
        logic             valid;
        logic             read;
        logic             dw;
        logic             lo_half;
        csr_region_e      region;
        logic [SEL_W-1:0] sel;
    } csr_acc_t;

    // PSL bits [32:63] are the numerically low word, selected by address[23]=1.
    function automatic logic [63:0] half_mask(input logic dw, input logic lo_half);
        if (dw)
            return '1;
        else if (lo_half)
            return {32'h0000_0000, 32'hFFFF_FFFF};
        else
            return {32'hFFFF_FFFF, 32'h0000_0000};
    endfunction

    // 32-bit reads return the selected half replicated onto both halves.
    function automatic logic [63:0] read_mux(input logic dw, input logic lo_half,
                                             input logic [63:0] value);
        if (dw)
            return value;
        else if (lo_half)
            return {value[31:0], value[31:0]};
        else
            return {value[63:32], value[63:32]};
    endfunction

endpackage

// File: rtl/mmio_csr_bank_parity.sv
// mmio_csr_bank_parity: odd-parity generator.
//   data_i   [BITS-1:0] in   word to protect
//   parity_o            out  bit making (data_i, parity_o) contain an odd number of ones
module mmio_csr_bank_parity #(
    parameter int unsigned BITS = 64
) (
    input  logic [BITS-1:0] data_i,
    output logic            parity_o
);

    assign parity_o = ~^data_i;

endmodule

// File: rtl/mmio_csr_bank.sv
// mmio_csr_bank: parametrised PSL MMIO control/status register bank.
//   Window (relative to BASE_ADDR): NUM_CTRL control regs, NUM_STATUS sticky W1C
//   status regs, NUM_STATUS raw status views; everything else reads 0.
//   Pipeline: T+1 capture, T+2 decode, T+3 update/read mux, T+4 ack + data.
// Ports:
//   clock, reset            sole clock; async active-high reset, sync release
//   mmio_in                 PSL MMIO request
//   mmio_out                ack (one cycle), read data, odd data parity
//   ctrl_out   [NUM_CTRL]   control register values
//   status_in  [NUM_STATUS] per-cycle sticky set bits
//   status_clr [NUM_STATUS] one-cycle host clear mask
//   mmio_errors             {data parity, address parity} error pulses
// Build option: MMIO_PARITY_CHECK_EN enables request parity checking; bad-parity
// writes are acked without committing.
module mmio_csr_bank
    import mmio_csr_bank_pkg::*;
#(
    parameter logic [0:23]          BASE_ADDR       = 24'h00_0000,
    parameter int unsigned          NUM_CTRL        = 4,
    parameter int unsigned          NUM_STATUS      = 4,
    parameter logic [NUM_CTRL-1:0]  CTRL_PULSE_MASK = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  MMIOInterfaceInput            mmio_in,
    output MMIOInterfaceOutput           mmio_out,
    output logic [NUM_CTRL-1:0][63:0]    ctrl_out,
    input  logic [NUM_STATUS-1:0][63:0]  status_in,
    output logic [NUM_STATUS-1:0][63:0]  status_clr,
    output logic [1:0]                   mmio_errors
);

    localparam logic [22:0]      BASE_DW    = BASE_ADDR[0:22];
    localparam logic [IDX_W-1:0] CTRL_END   = IDX_W'(NUM_CTRL);
    localparam logic [IDX_W-1:0] STICKY_END = IDX_W'(NUM_CTRL + NUM_STATUS);
    localparam logic [IDX_W-1:0] RAW_END    = IDX_W'(NUM_CTRL + 2 * NUM_STATUS);

    MMIOInterfaceInput req_q;
    csr_dec_t          dec_d, dec_q;
    csr_acc_t          acc_q;

    logic [NUM_CTRL-1:0][63:0]   ctrl_d, ctrl_q;
    logic [NUM_STATUS-1:0][63:0] sticky_d, sticky_q;
    logic [NUM_STATUS-1:0][63:0] clr_d, clr_q;
    mmio_err_t                   err_q;
    logic                        ack_q;
    logic [63:0]                 rdata_d, rdata_q;
    logic                        out_par;

    logic             addr_err, data_err;
    logic [22:0]      dw_addr, dw_off;
    logic [IDX_W-1:0] idx, rel;
    logic             wr_en;
    logic [63:0]      wmask;
    logic [63:0]      rd_value;

    // Stage 1: capture request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            req_q <= '0;
        else
            req_q <= mmio_in;
    end

`ifdef MMIO_PARITY_CHECK_EN
    logic addr_par, data_par;

    mmio_csr_bank_parity #(.BITS(24)) u_addr_par (
        .data_i   (req_q.address),
        .parity_o (addr_par)
    );

    mmio_csr_bank_parity #(.BITS(64)) u_data_par (
        .data_i   (req_q.data),
        .parity_o (data_par)
    );

    assign addr_err = req_q.valid & (addr_par != req_q.address_parity);
    assign data_err = req_q.valid & ~req_q.read & (data_par != req_q.data_parity);
`else
    logic unused_req_parity;
    assign unused_req_parity = ^{req_q.address_parity, req_q.data_parity};
    assign addr_err = 1'b0;
    assign data_err = 1'b0;
`endif

    // Stage 2: decode. Addresses below the base are excluded explicitly because
    // the subtraction would otherwise wrap into a huge index.
    always_comb begin
        dw_addr        = req_q.address[0:22];
        dw_off         = dw_addr - BASE_DW;
        idx            = dw_off[22:1];
        rel            = '0;
        dec_d          = '0;
        dec_d.valid    = req_q.valid;
        dec_d.read     = req_q.read;
        dec_d.dw       = req_q.doubleword;
        dec_d.lo_half  = req_q.address[23];
        dec_d.wdata    = req_q.data;
        dec_d.err      = {data_err, addr_err};
        dec_d.commit   = ~(addr_err | data_err);
        dec_d.region   = REGION_NONE;
        if (!req_q.cfg && (dw_addr >= BASE_DW)) begin
            if (idx < CTRL_END) begin
                dec_d.region = REGION_CTRL;
                rel          = idx;
            end else if (idx < STICKY_END) begin
                dec_d.region = REGION_STICKY;
                rel          = idx - CTRL_END;
            end else if (idx < RAW_END) begin
                dec_d.region = REGION_RAW;
                rel          = idx - STICKY_END;
            end
        end
        dec_d.sel = rel[SEL_W-1:0];
    end

    logic unused_decode;
    assign unused_decode = ^{dw_off[0], rel[IDX_W-1:SEL_W]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            dec_q <= '0;
        else
            dec_q <= dec_d;
    end

    // Stage 3: register update. Pulse registers fall back to 0 every cycle
    // unless written, so a written value is visible for exactly one cycle.
    assign wr_en = dec_q.valid & ~dec_q.read & dec_q.commit;
    assign wmask = half_mask(dec_q.dw, dec_q.lo_half);

    always_comb begin
        for (int unsigned i = 0; i < NUM_CTRL; i++) begin
            ctrl_d[i] = CTRL_PULSE_MASK[i] ? '0 : ctrl_q[i];
            if (wr_en && (dec_q.region == REGION_CTRL) && (dec_q.sel == SEL_W'(i)))
                ctrl_d[i] = (ctrl_d[i] & ~wmask) | (dec_q.wdata & wmask);
        end
        for (int unsigned j = 0; j < NUM_STATUS; j++) begin
            clr_d[j] = '0;
            if (wr_en && (dec_q.region == REGION_STICKY) && (dec_q.sel == SEL_W'(j)))
                clr_d[j] = dec_q.wdata & wmask;
            // The clear mask is applied while it is visible on status_clr;
            // OR-ing status_in last lets a same-cycle set win.
            sticky_d[j] = (sticky_q[j] & ~clr_q[j]) | status_in[j];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q   <= '0;
            clr_q    <= '0;
            sticky_q <= '0;
            err_q    <= MMIO_ERR_NONE;
            acc_q    <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            clr_q         <= clr_d;
            sticky_q      <= sticky_d;
            err_q         <= dec_q.valid ? dec_q.err : MMIO_ERR_NONE;
            acc_q.valid   <= dec_q.valid;
            acc_q.read    <= dec_q.read;
            acc_q.dw      <= dec_q.dw;
            acc_q.lo_half <= dec_q.lo_half;
            acc_q.region  <= dec_q.region;
            acc_q.sel     <= dec_q.sel;
        end
    end

    // Read mux samples current sticky and raw status during T+3.
    always_comb begin
        rd_value = '0;
        if (acc_q.valid && acc_q.read) begin
            for (int unsigned i = 0; i < NUM_CTRL; i++) begin
                if ((acc_q.region == REGION_CTRL) && (acc_q.sel == SEL_W'(i)) &&
                    !CTRL_PULSE_MASK[i])
                    rd_value = ctrl_q[i];
            end
            for (int unsigned j = 0; j < NUM_STATUS; j++) begin
                if ((acc_q.region == REGION_STICKY) && (acc_q.sel == SEL_W'(j)))
                    rd_value = sticky_q[j];
                if ((acc_q.region == REGION_RAW) && (acc_q.sel == SEL_W'(j)))
                    rd_value = status_in[j];
            end
        end
        rdata_d = read_mux(acc_q.dw, acc_q.lo_half, rd_value);
    end

    // Stage 4: registered response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= acc_q.valid;
            rdata_q <= rdata_d;
        end
    end

    mmio_csr_bank_parity #(.BITS(64)) u_out_par (
        .data_i   (rdata_q),
        .parity_o (out_par)
    );

    assign mmio_out    = '{ack: ack_q, data: rdata_q, data_parity: out_par};
    assign ctrl_out    = ctrl_q;
    assign status_clr  = clr_q;
    assign mmio_errors = err_q;

endmodule

// File: tb/tb_mmio_csr_bank.sv
// tb_mmio_csr_bank: directed self-checking bench for mmio_csr_bank.
// Register map with BASE_ADDR=0x100: idx k at address 0x100 + 4k, +1 selects
// the low (PSL [32:63]) word. idx 0..3 ctrl (idx 0 pulse), 4..7 sticky, 8..11 raw.
module tb_mmio_csr_bank;
    import mmio_csr_bank_pkg::*;

    localparam int unsigned NC = 4;
    localparam int unsigned NS = 4;
    localparam logic [63:0] V1 = 64'h0123_4567_89AB_CDEF;

    logic                clock = 1'b0;
    logic                reset;
    MMIOInterfaceInput   mmio_in;
    MMIOInterfaceOutput  mmio_out;
    logic [NC-1:0][63:0] ctrl_out;
    logic [NS-1:0][63:0] status_in;
    logic [NS-1:0][63:0] status_clr;
    logic [1:0]          mmio_errors;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned acks;

    logic                ack_s  [1:5];
    logic [63:0]         data_s [1:5];
    logic                par_s  [1:5];
    logic [1:0]          err_s  [1:5];
    logic [NC-1:0][63:0] ctrl_s [1:5];
    logic [NS-1:0][63:0] clr_s  [1:5];

    always #5 clock = ~clock;

    mmio_csr_bank #(
        .BASE_ADDR       (24'h00_0100),
        .NUM_CTRL        (NC),
        .NUM_STATUS      (NS),
        .CTRL_PULSE_MASK (4'b0001)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mmio_in     (mmio_in),
        .mmio_out    (mmio_out),
        .ctrl_out    (ctrl_out),
        .status_in   (status_in),
        .status_clr  (status_clr),
        .mmio_errors (mmio_errors)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One access issued at negedge N0; observations taken at negedges N1..N5
    // (N3 = cycle T+3, N4 = cycle T+4). set0_t3 is driven on status_in[0]
    // during cycle T+3 only.
    task automatic xact(input logic rd, input logic dw, input logic cfg,
                        input logic [23:0] addr, input logic [63:0] wdata,
                        input logic bad_par, input logic [63:0] set0_t3);
        @(negedge clock);
        mmio_in.valid          = 1'b1;
        mmio_in.cfg            = cfg;
        mmio_in.read           = rd;
        mmio_in.doubleword     = dw;
        mmio_in.address        = addr;
        mmio_in.address_parity = ~^addr;
        mmio_in.data           = wdata;
        mmio_in.data_parity    = (~^wdata) ^ bad_par;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 1) mmio_in = '0;
            ack_s[k]  = mmio_out.ack;
            data_s[k] = mmio_out.data;
            par_s[k]  = mmio_out.data_parity;
            err_s[k]  = mmio_errors;
            ctrl_s[k] = ctrl_out;
            clr_s[k]  = status_clr;
            if (k == 3) status_in[0] = set0_t3;
            if (k == 4) status_in[0] = '0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        mmio_in   = '0;
        status_in = '0;
        repeat (3) @(negedge clock);
        check("rst_hold_parity", 64'(mmio_out.data_parity), 64'd1);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ack",    64'(mmio_out.ack), 64'd0);
        check("rst_data",   mmio_out.data, 64'd0);
        check("rst_parity", 64'(mmio_out.data_parity), 64'd1);
        check("rst_errors", 64'(mmio_errors), 64'd0);
        for (int i = 0; i < NC; i++) check("rst_ctrl", ctrl_out[i], 64'd0);
        for (int j = 0; j < NS; j++) check("rst_clr", status_clr[j], 64'd0);

        // Level control register idx 1.
        xact(1'b0, 1'b1, 1'b0, 24'h000104, V1, 1'b0, 64'd0);
        check("lvl_ctrl_t2", ctrl_s[2][1], 64'd0);
        check("lvl_ctrl_t3", ctrl_s[3][1], V1);
        check("lvl_ctrl_t5", ctrl_s[5][1], V1);
        check("lvl_ack_t3",  64'(ack_s[3]), 64'd0);
        check("lvl_ack_t4",  64'(ack_s[4]), 64'd1);
        check("lvl_ack_t5",  64'(ack_s[5]), 64'd0);
        xact(1'b1, 1'b1, 1'b0, 24'h000104, 64'd0, 1'b0, 64'd0);
        check("lvl_rd_ack",  64'(ack_s[4]), 64'd1);
        check("lvl_rd_data", data_s[4], V1);
        check("lvl_rd_par",  64'(par_s[4]), 64'd1);

        // Pulse control register idx 0.
        xact(1'b0, 1'b1, 1'b0, 24'h000100, 64'h5, 1'b0, 64'd0);
        check("pls_ctrl_t2", ctrl_s[2][0], 64'd0);
        check("pls_ctrl_t3", ctrl_s[3][0], 64'h5);
        check("pls_ctrl_t4", ctrl_s[4][0], 64'd0);
        check("pls_other",   ctrl_s[3][1], V1);
        xact(1'b1, 1'b1, 1'b0, 24'h000100, 64'd0, 1'b0, 64'd0);
        check("pls_rd_data", data_s[4], 64'd0);
        check("pls_rd_par",  64'(par_s[4]), 64'd1);

        // Sticky W1C, channel 0 (idx 4).
        @(negedge clock); status_in[0] = 64'h3;
        @(negedge clock); status_in[0] = 64'h0;
        xact(1'b1, 1'b1, 1'b0, 24'h000110, 64'd0, 1'b0, 64'd0);
        check("stk_rd3",     data_s[4], 64'h3);
        check("stk_rd3_par", 64'(par_s[4]), 64'd1);
        xact(1'b0, 1'b1, 1'b0, 24'h000110, 64'h1, 1'b0, 64'd0);
        check("stk_clr_t2", clr_s[2][0], 64'd0);
        check("stk_clr_t3", clr_s[3][0], 64'h1);
        check("stk_clr_t4", clr_s[4][0], 64'd0);
        check("stk_wr_ack", 64'(ack_s[4]), 64'd1);
        xact(1'b1, 1'b1, 1'b0, 24'h000110, 64'd0, 1'b0, 64'd0);
        check("stk_rd2",     data_s[4], 64'h2);
        check("stk_rd2_par", 64'(par_s[4]), 64'd0);
        xact(1'b0, 1'b1, 1'b0, 24'h000110, 64'h2, 1'b0, 64'h2);
        check("stk_race_clr", clr_s[3][0], 64'h2);
        xact(1'b1, 1'b1, 1'b0, 24'h000110, 64'd0, 1'b0, 64'd0);
        check("stk_race_set_wins", data_s[4], 64'h2);
        xact(1'b0, 1'b1, 1'b0, 24'h000110, 64'h2, 1'b0, 64'd0);
        xact(1'b1, 1'b1, 1'b0, 24'h000110, 64'd0, 1'b0, 64'd0);
        check("stk_cleared", data_s[4], 64'd0);

        // Sticky vs raw view of channel 1, raw view of channel 2.
        @(negedge clock); status_in[1] = 64'hA0;
        @(negedge clock); status_in[1] = 64'h0; status_in[2] = 64'h55;
        xact(1'b1, 1'b1, 1'b0, 24'h000114, 64'd0, 1'b0, 64'd0);
        check("stk1_rd", data_s[4], 64'hA0);
        xact(1'b1, 1'b1, 1'b0, 24'h000124, 64'd0, 1'b0, 64'd0);
        check("raw1_rd", data_s[4], 64'd0);
        xact(1'b1, 1'b1, 1'b0, 24'h000128, 64'd0, 1'b0, 64'd0);
        check("raw2_rd",  data_s[4], 64'h55);
        check("raw2_par", 64'(par_s[4]), 64'd1);
        status_in[2] = 64'h0;

        // 32-bit accesses on ctrl idx 2.
        xact(1'b0, 1'b1, 1'b0, 24'h000108, 64'h1111_2222_3333_4444, 1'b0, 64'd0);
        xact(1'b0, 1'b0, 1'b0, 24'h000109, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 64'd0);
        check("w32_lo", ctrl_s[3][2], 64'h1111_2222_DEAD_BEEF);
        xact(1'b1, 1'b0, 1'b0, 24'h000109, 64'd0, 1'b0, 64'd0);
        check("r32_lo",     data_s[4], 64'hDEAD_BEEF_DEAD_BEEF);
        check("r32_lo_par", 64'(par_s[4]), 64'd1);
        xact(1'b1, 1'b0, 1'b0, 24'h000108, 64'd0, 1'b0, 64'd0);
        check("r32_hi", data_s[4], 64'h1111_2222_1111_2222);
        xact(1'b0, 1'b0, 1'b0, 24'h000108, 64'hCAFE_F00D_0000_0000, 1'b0, 64'd0);
        check("w32_hi", ctrl_s[3][2], 64'hCAFE_F00D_DEAD_BEEF);

        // Write with corrupted data parity to ctrl idx 3.
        xact(1'b0, 1'b1, 1'b0, 24'h00010C, 64'h77, 1'b1, 64'd0);
        check("par_ack", 64'(ack_s[4]), 64'd1);
`ifdef MMIO_PARITY_CHECK_EN
        check("par_ctrl_t3", ctrl_s[3][3], 64'd0);
        check("par_ctrl_t4", ctrl_s[4][3], 64'd0);
        check("par_err_t2",  64'(err_s[2]), 64'd0);
        check("par_err_t3",  64'(err_s[3]), 64'h2);
        check("par_err_t4",  64'(err_s[4]), 64'd0);
`else
        check("par_ctrl_t3", ctrl_s[3][3], 64'h77);
        check("par_err_t3",  64'(err_s[3]), 64'd0);
`endif

        // Out-of-window, below-base and cfg accesses.
        xact(1'b1, 1'b1, 1'b0, 24'h000134, 64'd0, 1'b0, 64'd0);
        check("oow_rd_ack",  64'(ack_s[4]), 64'd1);
        check("oow_rd_data", data_s[4], 64'd0);
        xact(1'b0, 1'b1, 1'b0, 24'h000134, '1, 1'b0, 64'd0);
        check("oow_wr_ctrl1", ctrl_s[4][1], V1);
        check("oow_wr_ctrl2", ctrl_s[4][2], 64'hCAFE_F00D_DEAD_BEEF);
        check("oow_wr_clr",   clr_s[3][0], 64'd0);
        xact(1'b1, 1'b1, 1'b0, 24'h0000FC, 64'd0, 1'b0, 64'd0);
        check("below_rd_ack",  64'(ack_s[4]), 64'd1);
        check("below_rd_data", data_s[4], 64'd0);
        xact(1'b1, 1'b1, 1'b1, 24'h000104, 64'd0, 1'b0, 64'd0);
        check("cfg_rd_ack",  64'(ack_s[4]), 64'd1);
        check("cfg_rd_data", data_s[4], 64'd0);
        xact(1'b0, 1'b1, 1'b1, 24'h000104, 64'd0, 1'b0, 64'd0);
        check("cfg_wr_ctrl1", ctrl_s[4][1], V1);

        // Reset asserted while a read is in flight.
        @(negedge clock);
        mmio_in.valid          = 1'b1;
        mmio_in.read           = 1'b1;
        mmio_in.doubleword     = 1'b1;
        mmio_in.address        = 24'h000104;
        mmio_in.address_parity = ~^24'h000104;
        @(negedge clock);
        mmio_in = '0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rstmid_ctrl1_async", ctrl_out[1], 64'd0);
        check("rstmid_ctrl2_async", ctrl_out[2], 64'd0);
        check("rstmid_parity",      64'(mmio_out.data_parity), 64'd1);
        @(negedge clock);
        reset = 1'b0;
        acks  = 0;
        repeat (6) begin
            @(negedge clock);
            if (mmio_out.ack) acks++;
        end
        check("rstmid_no_ack", 64'(acks), 64'd0);
        xact(1'b1, 1'b1, 1'b0, 24'h000114, 64'd0, 1'b0, 64'd0);
        check("rstmid_sticky1", data_s[4], 64'd0);
        check("rstmid_rd_ack",  64'(ack_s[4]), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_csr_bank.md
# mmio_csr_bank

Parametrised MMIO control/status register bank for the AFU, the generalised successor to the fixed-map MMIO block. It decodes PSL MMIO reads and writes into a configurable window of NUM_CTRL control registers and NUM_STATUS sticky write-1-to-clear status channels, each with a per-channel clear strobe. It answers every access with a fixed-latency ack and odd-parity read data. It sits between the PSL MMIO interface and the algorithm control / error-reporting logic.

## Interface
- BASE_ADDR, 24'h00_0000: word address of register index 0; even.
- NUM_CTRL, 4: control registers, 1..16.
- NUM_STATUS, 4: sticky status channels, 1..16.
- CTRL_PULSE_MASK, '0: NUM_CTRL bits; bit i=1 makes control register i a one-cycle pulse register, bit i=0 makes it level.
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- mmio_in  in  MMIOInterfaceInput  valid, cfg, read, doubleword, address[0:23], address_parity, data[0:63], data_parity.
- mmio_out  out  MMIOInterfaceOutput  ack, data[0:63], data_parity.
- ctrl_out  out  NUM_CTRL x 64  control register values.
- status_in  in  NUM_STATUS x 64  per-cycle set bits.
- status_clr  out  NUM_STATUS x 64  one-cycle mask of bits cleared by host.
- mmio_errors  out  2  {data parity error, address parity error}, one-cycle pulses.

## Operation
- Index: idx = (address[0:22] − BASE_ADDR[0:22]) >> 1.
- idx in [0, NUM_CTRL): control register, read/write.
- idx in [NUM_CTRL, NUM_CTRL+NUM_STATUS): sticky status register, read; a write clears the bits written as 1 (W1C).
- Next NUM_STATUS indices: raw status_in, read-only.
- Anything else, and any address below BASE_ADDR: read returns 0, write is ignored. The access is still acked.
- cfg=1 accesses are acked with data 0 and have no side effects.
- 32-bit accesses: address[23]=0 selects bits [0:31], =1 selects bits [32:63].
  - A write updates only the selected half, taking data from the same half of mmio_in.data.
  - A read returns the selected half replicated onto both halves.
- Sticky update every cycle: sticky = (sticky & ~clr) | status_in. When set and clear hit the same bit in the same cycle, set wins.
- status_clr equals the effective W1C mask for one cycle, coincident with the sticky update.
- Pulse control registers read back 0 and return to 0 one cycle after the write lands.
- Level control registers hold their value until rewritten.
- Read data is registered. mmio_out.data_parity is odd parity over mmio_out.data.

## Timing
- Request pipeline: mmio_in registered at T+1, decode at T+2, register update and read mux at T+3, mmio_out.ack high for exactly one cycle at T+4 with data valid in the same cycle.
- One outstanding access (PSL rule); a second valid while the first is in flight is not supported.
- A write lands at T+3: ctrl_out and status_clr change at T+3, and a pulse register is 0 again at T+4.
- A read samples sticky and raw status at T+3.
- mmio_errors pulses at T+3.
- Reset (async assert, sync release):
  - all ctrl_out, sticky, status_clr = 0;
  - mmio_out.ack = 0, data = 0, data_parity = 1;
  - mmio_errors = 0.
- Reset mid-access drops the access; no ack is issued.

## Configuration
- MMIO_PARITY_CHECK_EN defined:
  - address parity and write-data parity are checked at T+2;
  - a bad-parity write is acked but not committed;
  - the matching mmio_errors bit pulses at T+3.
- Undefined:
  - no checking, mmio_errors tied 00;
  - every write commits.
- Output parity is generated in both builds.

## Structure
- AFU_PKG gets the index-region offset localparams, the 2-bit MMIO error encoding, and a read-mux helper function.
- The existing parity module #(BITS) is reused for output parity, and under the macro for address (24) and data (64) checks.
- No other sub-modules.

## Test plan
- Reset: assert reset mid-access -> no ack; all outputs at their reset values; data_parity=1.
- Level control: doubleword write 64'h0123_4567_89AB_CDEF to idx 1 at T -> ctrl_out[1] changes at T+3; readback ack at its T+4 with same data and correct odd parity.
- Pulse control (CTRL_PULSE_MASK bit 0=1): write 64'h5 to idx 0 -> ctrl_out[0]=5 for one cycle only; readback returns 0.
- Sticky W1C: status_in[0] pulses 64'h3 -> read idx NUM_CTRL returns 3; W1C 64'h1 -> status_clr[0]=1 for one cycle, read returns 2. A same-cycle set of bit 1 during a W1C of 64'h2 leaves bit 1 set.
- 32-bit access: write 32'hDEAD_BEEF with address[23]=1 -> only bits [32:63] change; 32-bit read of that half returns 64'hDEADBEEF_DEADBEEF.
- Parity (macro on): write with flipped data_parity -> register unchanged, ack at T+4, mmio_errors=2'b10 for one cycle. Out-of-window read -> data 0, acked.
